iterative_shifter_unit: RTL and testbench
=========================================

// Module: iterative_shifter_unit
// PURPOSE
//   Multi-cycle shift unit for the ARC datapath. Successor to the combinational shift
//   decode: it now owns operand capture, the shift itself and a start/done handshake.
//   Parametrised in width and bits-per-cycle, and adds SRA, SLL and ROR modes.
//   Sits beside the ALU; the controller issues start and stalls while busy is high.
// PARAMETERS
//   DATA_W  32  operand/result width, >= 2
//   SA_W    5   shift-amount width, = clog2(DATA_W)
//   STEP    1   max bits shifted per clock, 1..DATA_W
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       request; accepted only when state is IDLE or DONE
//   func         in   4       ALU function code (decoded below)
//   operand      in   DATA_W  value to shift
//   bus_b        in   SA_W    variable shift amount (modes 4-7)
//   busy         out  1       high while state==SHIFT
//   done         out  1       one-cycle completion pulse
//   result       out  DATA_W  shifted value, held until next accept
//   carry_out    out  1       last bit shifted out; 0 if sa==0
//   shift_right  out  1       latched direction of current/last op
//   sa           out  SA_W    latched shift amount of current/last op
// BEHAVIOUR
//   - Decode (sampled on accept): 4 SRL sa=bus_b; 5 SRA sa=bus_b; 6 SLL sa=bus_b;
//     7 ROR sa=bus_b; 9 LSHIFT2 sa=2; 10 LSHIFT10 sa=10; others: no shift, sa=0.
//   - Fixed-amount modes ignore bus_b. If the fixed amount >= DATA_W: result=0 and
//     carry_out=0 in N=0 cycles.
//   - shift_right=1 for SRL/SRA/ROR, else 0.
//   - Reset (async, rst_n=0): state=IDLE; result, sa, shift_right, carry_out, busy and
//     done all 0. This applies mid-operation; the op is dropped and never reports done.
//   - FSM states: IDLE, SHIFT, DONE.
//     - Accepting edge: latch operand, mode and sa; go to SHIFT, or to DONE if N==0.
//     - SHIFT: each edge shifts by min(STEP, remaining) and decrements remaining. The
//       edge that zeroes remaining moves to DONE.
//     - DONE: done=1 for exactly one cycle. Next edge goes to SHIFT/DONE if start=1
//       (back-to-back accept), else to IDLE.
//   - Latency: N = ceil(sa/STEP). done is visible in the cycle following edge
//     accept+N. Throughput is one op per N+1 cycles.
//   - start while busy is ignored; no queueing. Inputs are sampled only at accept.
//   - Per-step arithmetic:
//     - SRL zero-fills.
//     - SRA replicates operand[DATA_W-1].
//     - SLL, LSHIFT2 and LSHIFT10 zero-fill from the LSB.
//     - ROR feeds the LSBs into the MSBs.
//   - carry_out = the last bit pushed out of the word. For ROR it is the last bit
//     rotated from bit0, i.e. result[DATA_W-1].
//   - sa uses all SA_W bits; it is never reduced modulo anything, so sa < DATA_W by
//     construction.
//   - result updates only on DONE entry. It is stable and valid from done until the
//     next accept.
// TESTING (DATA_W=32, STEP=4)
//   1. SRL, operand=0x8000_0000, bus_b=31
//      -> result=0x0000_0001, carry_out=0, busy for 8 cycles, done after edge accept+8.
//   2. SRA, operand=0x8000_0000, bus_b=4
//      -> result=0xF800_0000, carry_out=0, done after edge accept+1.
//   3. ROR, operand=0x0000_00F1, bus_b=4
//      -> result=0x1000_000F, carry_out=0.
//      ROR by 1 on 0x0000_0001 -> result 0x8000_0000, carry_out=1.
//   4. LSHIFT10, operand=0x0000_0001, bus_b=0x1F
//      -> result=0x0000_0400 (bus_b ignored), done after edge accept+3.
//      Unknown func 0 -> result=operand, done after edge accept+0.
//   5. Pulse start again while busy (different operand)
//      -> ignored, first result unchanged.
//      Assert start in the DONE cycle -> new op accepted with no IDLE gap.
//   6. rst_n=0 two cycles into a 31-bit SRL
//      -> busy/done/result go to 0 immediately; after release, IDLE with no done pulse.

Source files
------------

// File: rtl/iterative_shifter_unit.sv
// ---------------------------------------------------------------------------
// iterative_shifter_unit
//   Multi-cycle shift unit that sits beside the ALU. It captures the operand
//   and the decoded shift mode on an accepted start, shifts by up to STEP bits
//   per clock, then reports the result with a one-cycle done pulse. The
//   controller stalls while busy is high.
//
//   func codes: 4 SRL, 5 SRA, 6 SLL, 7 ROR (amount from bus_b),
//               9 LSHIFT2, 10 LSHIFT10 (fixed amount), others pass-through.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only in IDLE or DONE
//   func         ALU function code
//   operand      value to shift
//   bus_b        variable shift amount (func 4-7)
//   busy         high while shifting
//   done         one-cycle completion pulse
//   result       shifted value, held until the next accept
//   carry_out    last bit pushed out of the word (0 when nothing shifted)
//   shift_right  latched direction of the current/last op
//   sa           latched shift amount of the current/last op
// ---------------------------------------------------------------------------
module iterative_shifter_unit #(
    parameter int DATA_W = 32,
    parameter int SA_W   = 5,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] operand,
    input  logic [SA_W-1:0]   bus_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              shift_right,
    output logic [SA_W-1:0]   sa
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] M_SRL = 2'd0;
    localparam logic [1:0] M_SRA = 2'd1;
    localparam logic [1:0] M_SLL = 2'd2;
    localparam logic [1:0] M_ROR = 2'd3;

    localparam logic [SA_W:0] STEP_V = (SA_W + 1)'(STEP);

    // Fixed-amount modes whose amount does not fit in the word collapse to a
    // zero result with no shifting at all.
    localparam bit              FIX2_ZERO  = (DATA_W <= 2);
    localparam bit              FIX10_ZERO = (DATA_W <= 10);
    localparam logic [SA_W-1:0] FIX2_SA    = FIX2_ZERO  ? '0 : SA_W'(2);
    localparam logic [SA_W-1:0] FIX10_SA   = FIX10_ZERO ? '0 : SA_W'(10);

    state_t            state, next_state;
    logic [1:0]        mode_q;
    logic [SA_W-1:0]   rem;
    logic [DATA_W-1:0] work;

    logic [1:0]        dec_mode;
    logic [SA_W-1:0]   dec_sa;
    logic              dec_right;
    logic              dec_zero;

    logic              accept;
    logic              last_step;
    logic [SA_W:0]     step_k;
    logic [DATA_W:0]   step_res;

    // Shift w_in by k single-bit steps (k <= STEP) in the given mode.
    // Returns {last bit pushed out, shifted word}.
    function automatic logic [DATA_W:0] step_shift(
        input logic [DATA_W-1:0] w_in,
        input logic [1:0]        mode,
        input logic [SA_W:0]     k
    );
        logic [DATA_W-1:0]        w;
        logic signed [DATA_W-1:0] ws;
        logic                     c;
        w  = w_in;
        ws = '0;
        c  = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                case (mode)
                    M_SRL: begin
                        c = w[0];
                        w = {1'b0, w[DATA_W-1:1]};
                    end
                    M_SRA: begin
                        c  = w[0];
                        ws = w;
                        ws = ws >>> 1;
                        w  = ws;
                    end
                    M_SLL: begin
                        c = w[DATA_W-1];
                        w = {w[DATA_W-2:0], 1'b0};
                    end
                    default: begin
                        c = w[0];
                        w = {w[0], w[DATA_W-1:1]};
                    end
                endcase
            end
        end
        return {c, w};
    endfunction

    // Function decode; only used on the accepting edge.
    always_comb begin
        dec_mode  = M_SLL;
        dec_sa    = '0;
        dec_right = 1'b0;
        dec_zero  = 1'b0;
        case (func)
            4'd4: begin dec_mode = M_SRL; dec_sa = bus_b; dec_right = 1'b1; end
            4'd5: begin dec_mode = M_SRA; dec_sa = bus_b; dec_right = 1'b1; end
            4'd6: begin dec_mode = M_SLL; dec_sa = bus_b; end
            4'd7: begin dec_mode = M_ROR; dec_sa = bus_b; dec_right = 1'b1; end
            4'd9: begin dec_sa = FIX2_SA;  dec_zero = FIX2_ZERO;  end
            4'd10: begin dec_sa = FIX10_SA; dec_zero = FIX10_ZERO; end
            default: ;
        endcase
    end

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = ({1'b0, rem} <= STEP_V);
    assign step_k    = last_step ? {1'b0, rem} : STEP_V;
    assign step_res  = step_shift(work, mode_q, step_k);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = (dec_sa == '0) ? DONE : SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control and architecturally visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            carry_out   <= 1'b0;
            shift_right <= 1'b0;
            sa          <= '0;
            rem         <= '0;
            mode_q      <= M_SRL;
        end else if (accept) begin
            sa          <= dec_sa;
            rem         <= dec_sa;
            shift_right <= dec_right;
            mode_q      <= dec_mode;
            // Zero-length ops finish on this edge, so the result lands now.
            if (dec_sa == '0) begin
                result    <= dec_zero ? '0 : operand;
                carry_out <= 1'b0;
            end
        end else if (state == SHIFT) begin
            rem <= rem - step_k[SA_W-1:0];
            if (last_step) begin
                result    <= step_res[DATA_W-1:0];
                carry_out <= step_res[DATA_W];
            end
        end
    end

    // Working shift register; its content is meaningless outside SHIFT.
    always_ff @(posedge clk) begin
        if (accept) begin
            work <= operand;
        end else if (state == SHIFT) begin
            work <= step_res[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_iterative_shifter_unit.sv
module tb_iterative_shifter_unit;

    localparam int DATA_W = 32;
    localparam int SA_W   = 5;
    localparam int STEP   = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [3:0]        func;
    logic [DATA_W-1:0] operand;
    logic [SA_W-1:0]   bus_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carry_out;
    logic              shift_right;
    logic [SA_W-1:0]   sa;

    int checks;
    int errors;

    iterative_shifter_unit #(.DATA_W(DATA_W), .SA_W(SA_W), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .operand(operand),
        .bus_b(bus_b), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .shift_right(shift_right), .sa(sa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns 1 ns after the accepting edge.
    task automatic issue(input logic [3:0] f, input logic [DATA_W-1:0] op, input logic [SA_W-1:0] b);
        start   = 1'b1;
        func    = f;
        operand = op;
        bus_b   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the accept until done is seen (bounded), and the
    // number of sampled cycles with busy high before that.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; func = 4'd0; operand = '0; bus_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_out); end
        checks++; if (shift_right !== 1'b0) begin errors++; $display("FAIL reset_dir got %b exp 0", shift_right); end
        checks++; if (sa !== 5'd0) begin errors++; $display("FAIL reset_sa got %0d exp 0", sa); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_srl();
        int cyc, bcyc;
        issue(4'd4, 32'h8000_0000, 5'd31);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL srl_result got %h exp 00000001", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL srl_carry got %b exp 0", carry_out); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL srl_latency got %0d exp 8", cyc); end
        checks++; if (bcyc !== 8) begin errors++; $display("FAIL srl_busy_cycles got %0d exp 8", bcyc); end
        checks++; if (shift_right !== 1'b1) begin errors++; $display("FAIL srl_dir got %b exp 1", shift_right); end
        checks++; if (sa !== 5'd31) begin errors++; $display("FAIL srl_sa got %0d exp 31", sa); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL srl_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_sra();
        int cyc, bcyc;
        issue(4'd5, 32'h8000_0000, 5'd4);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result got %h exp F8000000", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sra_carry got %b exp 0", carry_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL sra_latency got %0d exp 1", cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_ror();
        int cyc, bcyc;
        issue(4'd7, 32'h0000_00F1, 5'd4);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h1000_000F) begin errors++; $display("FAIL ror4_result got %h exp 1000000F", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL ror4_carry got %b exp 0", carry_out); end
        @(posedge clk); #1;
        issue(4'd7, 32'h0000_0001, 5'd1);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL ror1_result got %h exp 80000000", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL ror1_carry got %b exp 1", carry_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL ror1_latency got %0d exp 1", cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_and_passthru();
        int cyc, bcyc;
        issue(4'd10, 32'h0000_0001, 5'h1F);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0400) begin errors++; $display("FAIL lsh10_result got %h exp 00000400", result); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL lsh10_latency got %0d exp 3", cyc); end
        checks++; if (sa !== 5'd10) begin errors++; $display("FAIL lsh10_sa got %0d exp 10", sa); end
        checks++; if (shift_right !== 1'b0) begin errors++; $display("FAIL lsh10_dir got %b exp 0", shift_right); end
        @(posedge clk); #1;
        issue(4'd9, 32'hC000_0001, 5'd7);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0004) begin errors++; $display("FAIL lsh2_result got %h exp 00000004", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL lsh2_carry got %b exp 1", carry_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL lsh2_latency got %0d exp 1", cyc); end
        @(posedge clk); #1;
        issue(4'd6, 32'h8000_0001, 5'd1);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0002) begin errors++; $display("FAIL sll1_result got %h exp 00000002", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL sll1_carry got %b exp 1", carry_out); end
        @(posedge clk); #1;
        issue(4'd0, 32'hDEAD_BEEF, 5'd9);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nop_result got %h exp DEADBEEF", result); end
        checks++; if (cyc !== 0) begin errors++; $display("FAIL nop_latency got %0d exp 0", cyc); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL nop_carry got %b exp 0", carry_out); end
        checks++; if (sa !== 5'd0) begin errors++; $display("FAIL nop_sa got %0d exp 0", sa); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int cyc, bcyc;
        issue(4'd4, 32'hF000_0000, 5'd8);
        // Second request arrives while the first op is shifting.
        start = 1'b1; func = 4'd0; operand = 32'h1234_5678; bus_b = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h00F0_0000) begin errors++; $display("FAIL ignore_result got %h exp 00F00000", result); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL ignore_latency got %0d exp 1", cyc); end
        @(posedge clk); #1;
        checks++; if (result !== 32'h00F0_0000) begin errors++; $display("FAIL ignore_hold got %h exp 00F00000", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ignore_extra_done got %b exp 0", done); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        issue(4'd4, 32'h0000_0100, 5'd4);
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0010) begin errors++; $display("FAIL b2b_first got %h exp 00000010", result); end
        // Request during the DONE cycle.
        issue(4'd6, 32'h0000_0003, 5'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_accept_done got %b exp 0", done); end
        wait_done(cyc, bcyc);
        checks++; if (result !== 32'h0000_0030) begin errors++; $display("FAIL b2b_second got %h exp 00000030", result); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_latency got %0d exp 1", cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        issue(4'd4, 32'hFFFF_FFFF, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h exp 0", result); end
        checks++; if (sa !== 5'd0) begin errors++; $display("FAIL midrst_sa got %0d exp 0", sa); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_done_pulses got %0d exp 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b exp 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_srl();
        test_sra();
        test_ror();
        test_fixed_and_passthru();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
